// File: rtl/counter_updown_mod_pkg.sv
// ============================================================================
// counter_pkg : shared types and limits for the up/down modulo counter
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} cnt_mode_t;

  localparam int PRESCALE_MAX = 65535;

endpackage

`default_nettype wire

// File: rtl/counter_updown_mod_if.sv
// ============================================================================
// counter_updown_mod_if : control and status bundle of the up/down counter
// Rev 1.0
// ============================================================================
`default_nettype none

interface counter_updown_mod_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             at_bound;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  count, tc, at_bound
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output count, tc, at_bound
  );
endinterface

`default_nettype wire

// File: rtl/counter_updown_mod_prescale_tick.sv
// ============================================================================
// prescale_tick : emits one step per PRESCALE enabled cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module prescale_tick
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic en,
  input  wire logic restart,
  output logic      step
);

  if (PRESCALE < 1 || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("prescale_tick: PRESCALE out of range");
  end

  if (PRESCALE == 1) begin : g_direct
    logic w_unused;
    assign w_unused = clk ^ reset ^ restart;
    assign step     = en;
  end else begin : g_div
    localparam int c_PW = $clog2(PRESCALE);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(PRESCALE - 1);

    logic [c_PW-1:0] r_p;
    logic            w_last;

    assign w_last = (r_p == c_LAST);
    assign step   = en & w_last;

    always_ff @(posedge clk) begin
      if (reset || restart) begin
        r_p <= '0;
      end else if (en) begin
        r_p <= w_last ? '0 : r_p + c_PW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_updown_mod.sv
// ============================================================================
// counter_updown_mod : up/down modulo counter with load, clear, prescaler,
//                      wrap/saturate mode and terminal-count pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 256,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input wire logic            clk,
  input wire logic            reset,
  counter_updown_mod_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 32 || MODULO < 2 ||
      longint'(MODULO) > (longint'(1) << WIDTH) ||
      (SATURATE != 0 && SATURATE != 1)) begin : g_bad_params
    $error("counter_updown_mod: illegal WIDTH/MODULO/SATURATE");
  end

  localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MODULO - 1);
  localparam cnt_mode_t        c_MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_next;
  logic             w_step;
  logic             w_at_bound;
  dir_t             w_dir;

  prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk     (clk),
    .reset   (reset),
    .en      (bus.en),
    .restart (bus.clear | bus.load),
    .step    (w_step)
  );

  assign w_dir      = dir_t'(bus.up_dn);
  assign w_at_bound = (w_dir == DIR_UP) ? (r_count == c_MAX) : (r_count == '0);

  // Explicit bound compare keeps values >= MODULO unreachable for any MODULO
  always_comb begin
    w_next = r_count;
    if (w_at_bound) begin
      if (c_MODE == MODE_WRAP) begin
        w_next = (w_dir == DIR_UP) ? '0 : c_MAX;
      end
    end else if (w_dir == DIR_UP) begin
      w_next = r_count + WIDTH'(1);
    end else begin
      w_next = r_count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (bus.load) begin
      r_count <= (bus.load_val > c_MAX) ? c_MAX : bus.load_val;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      r_count <= w_next;
      r_tc    <= w_at_bound;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign bus.count    = r_count;
  assign bus.tc       = r_tc;
  assign bus.at_bound = w_at_bound;

endmodule

`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
// ============================================================================
// tb_counter_updown_mod : scoreboard bench over four counter configurations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_updown_mod;

  typedef struct {
    int    id;
    int    cnt;
    bit    tc;
    string nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst [4];
  exp_t sb [$];
  int   nchecks = 0;
  int   nerrors = 0;

  always #5 clk = ~clk;

  // A: W2 M4 wrap P1, B: W4 M10 wrap P1, C: W4 M10 sat P1, D: W4 M16 wrap P3
  counter_updown_mod_if #(.WIDTH(2)) ifa ();
  counter_updown_mod_if #(.WIDTH(4)) ifb ();
  counter_updown_mod_if #(.WIDTH(4)) ifc ();
  counter_updown_mod_if #(.WIDTH(4)) ifd ();

  counter_updown_mod #(.WIDTH(2), .MODULO(4),  .SATURATE(0), .PRESCALE(1))
    u_a (.clk(clk), .reset(rst[0]), .bus(ifa));
  counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(1))
    u_b (.clk(clk), .reset(rst[1]), .bus(ifb));
  counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1), .PRESCALE(1))
    u_c (.clk(clk), .reset(rst[2]), .bus(ifc));
  counter_updown_mod #(.WIDTH(4), .MODULO(16), .SATURATE(0), .PRESCALE(3))
    u_d (.clk(clk), .reset(rst[3]), .bus(ifd));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int c, input bit t, input string nm);
    sb.push_back('{id: id, cnt: c, tc: t, nm: nm});
  endtask

  task automatic check(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation against the DUT it names
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   act_c, act_ab, md, exp_ab;
      bit   act_t, ud;
      e = sb.pop_front();
      case (e.id)
        0:       begin act_c = int'(ifa.count); act_t = ifa.tc; act_ab = int'(ifa.at_bound); ud = ifa.up_dn; md = 4;  end
        1:       begin act_c = int'(ifb.count); act_t = ifb.tc; act_ab = int'(ifb.at_bound); ud = ifb.up_dn; md = 10; end
        2:       begin act_c = int'(ifc.count); act_t = ifc.tc; act_ab = int'(ifc.at_bound); ud = ifc.up_dn; md = 10; end
        default: begin act_c = int'(ifd.count); act_t = ifd.tc; act_ab = int'(ifd.at_bound); ud = ifd.up_dn; md = 16; end
      endcase
      exp_ab = int'(ud ? (e.cnt == md - 1) : (e.cnt == 0));
      check({e.nm, ".count"}, act_c, e.cnt);
      check({e.nm, ".tc"}, int'(act_t), int'(e.tc));
      check({e.nm, ".at_bound"}, act_ab, exp_ab);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a [9];
    int exp_d [9];
    exp_a = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    exp_d = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

    for (int i = 0; i < 4; i++) rst[i] = 1'b1;
    {ifa.en, ifa.up_dn, ifa.clear, ifa.load} = 4'b0100; ifa.load_val = '0;
    {ifb.en, ifb.up_dn, ifb.clear, ifb.load} = 4'b0100; ifb.load_val = '0;
    {ifc.en, ifc.up_dn, ifc.clear, ifc.load} = 4'b0100; ifc.load_val = '0;
    {ifd.en, ifd.up_dn, ifd.clear, ifd.load} = 4'b0100; ifd.load_val = '0;
    cyc();
    push(0, 0, 0, "rst_a"); push(1, 0, 0, "rst_b");
    push(2, 0, 0, "rst_c"); push(3, 0, 0, "rst_d");
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // A: up-count wrap with tc on every wrap to zero
    ifa.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      push(0, exp_a[i], exp_a[i] == 0, $sformatf("a_up%0d", i));
    end
    ifa.en = 1'b0;

    // B: down wrap from zero, load clamp, clear overrides en
    ifb.up_dn = 1'b0; ifb.en = 1'b1;
    cyc(); push(1, 9, 1, "b_dn_wrap");
    cyc(); push(1, 8, 0, "b_dn8");
    cyc(); push(1, 7, 0, "b_dn7");
    ifb.en = 1'b0; ifb.load = 1'b1; ifb.load_val = 4'd13;
    cyc(); push(1, 9, 0, "b_clamp");
    ifb.load_val = 4'd4;
    cyc(); push(1, 4, 0, "b_load4");
    ifb.load = 1'b0; ifb.clear = 1'b1; ifb.en = 1'b1;
    cyc(); push(1, 0, 0, "b_clear");
    ifb.clear = 1'b0; ifb.en = 1'b0;

    // C: saturate at top, one tc per step while held, then leave downward
    ifc.load = 1'b1; ifc.load_val = 4'd8;
    cyc(); push(2, 8, 0, "c_load8");
    ifc.load = 1'b0; ifc.en = 1'b1;
    cyc(); push(2, 9, 0, "c_sat0");
    cyc(); push(2, 9, 1, "c_sat1");
    cyc(); push(2, 9, 1, "c_sat2");
    cyc(); push(2, 9, 1, "c_sat3");
    ifc.up_dn = 1'b0;
    cyc(); push(2, 8, 0, "c_down");
    ifc.en = 1'b0;
    cyc(); push(2, 8, 0, "c_hold");

    // D: prescale by 3, en gap delays the step exactly by the gap
    ifd.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      push(3, exp_d[i], 0, $sformatf("d_pre%0d", i));
    end
    cyc(); push(3, 3, 0, "d_ph1");
    ifd.en = 1'b0;
    cyc(); push(3, 3, 0, "d_gap0");
    cyc(); push(3, 3, 0, "d_gap1");
    ifd.en = 1'b1;
    cyc(); push(3, 3, 0, "d_ph2");
    cyc(); push(3, 4, 0, "d_step4");

    // D: clear beats load and en; load restarts the prescaler
    ifd.en = 1'b0; ifd.load = 1'b1; ifd.load_val = 4'd7;
    cyc(); push(3, 7, 0, "d_load7");
    ifd.clear = 1'b1; ifd.en = 1'b1; ifd.load_val = 4'd5;
    cyc(); push(3, 0, 0, "d_clr_pri");
    ifd.clear = 1'b0; ifd.load = 1'b0;
    cyc(); push(3, 0, 0, "d_p1");
    ifd.load = 1'b1;
    cyc(); push(3, 5, 0, "d_load5");
    ifd.load = 1'b0;
    cyc(); push(3, 5, 0, "d_rs1");
    cyc(); push(3, 5, 0, "d_rs2");
    cyc(); push(3, 6, 0, "d_rs3");

    // D: reset mid-phase (count 6, p=1) then first step after 3 enabled cycles
    cyc(); push(3, 6, 0, "d_p1b");
    rst[3] = 1'b1;
    cyc(); push(3, 0, 0, "d_reset");
    rst[3] = 1'b0;
    cyc(); push(3, 0, 0, "d_ar1");
    cyc(); push(3, 0, 0, "d_ar2");
    cyc(); push(3, 1, 0, "d_ar3");
    ifd.en = 1'b0;

    @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

`default_nettype wire
